// File: rtl/alu_sel_sequencer.sv
// Serialises a multi-hot 4-bit op request into {S1,S0}+enable selects for the ALU 2-to-4 decoder.
// Optional round-robin priority when ALU_SEL_RR_EN is defined (default: lowest index first).
module alu_sel_sequencer #(
    parameter int HOLD_CYCLES = 1,
    parameter int HOLD_W      = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] req,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic       flush,
    output logic       sel_s0,
    output logic       sel_s1,
    output logic       sel_enable,
    output logic       busy,
    output logic       batch_done
);

    typedef enum logic {
        S_IDLE,
        S_HOLD
    } state_t;

    localparam logic [HOLD_W-1:0] LP_HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);
    localparam logic [HOLD_W-1:0] LP_ONE       = HOLD_W'(1);

    state_t              r_state;
    logic [3:0]          r_pending;
    logic [HOLD_W-1:0]   r_cnt;
    logic [1:0]          r_idx;
    logic                r_en;
    logic                r_busy;
    logic                r_done;

    logic [3:0]          w_rem;
    logic [3:0]          w_src;
    logic [1:0]          w_start;
    logic [1:0]          w_next_idx;

    // First set bit of v, searching upward from start and wrapping 3->0.
    function automatic logic [1:0] f_pick(input logic [3:0] v, input logic [1:0] start);
        logic [1:0] k;
        logic [1:0] res;
        logic       hit;
        res = start;
        hit = 1'b0;
        for (int i = 0; i < 4; i++) begin
            k = start + 2'(i);
            if (!hit && v[k]) begin
                res = k;
                hit = 1'b1;
            end
        end
        return res;
    endfunction

`ifdef ALU_SEL_RR_EN
    logic [1:0] r_rr;
    assign w_start = r_rr;
`else
    assign w_start = 2'd0;
`endif

    // From IDLE the issue source is the incoming request; from HOLD it is what remains after the current op.
    assign w_rem      = r_pending & ~(4'b0001 << r_idx);
    assign w_src      = (r_state == S_IDLE) ? req : w_rem;
    assign w_next_idx = f_pick(w_src, w_start);

    assign req_ready  = (r_state == S_IDLE) & ~flush;
    assign sel_s0     = r_idx[0];
    assign sel_s1     = r_idx[1];
    assign sel_enable = r_en;
    assign busy       = r_busy;
    assign batch_done = r_done;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_pending <= 4'd0;
            r_cnt     <= '0;
            r_idx     <= 2'd0;
            r_en      <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
`ifdef ALU_SEL_RR_EN
            r_rr      <= 2'd0;
`endif
        end else begin
            r_done <= 1'b0;
            if (flush) begin
                r_state   <= S_IDLE;
                r_pending <= 4'd0;
                r_cnt     <= '0;
                r_en      <= 1'b0;
                r_busy    <= 1'b0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (req_valid) begin
                            if (req != 4'd0) begin
                                r_pending <= w_src;
                                r_idx     <= w_next_idx;
                                r_en      <= 1'b1;
                                r_busy    <= 1'b1;
                                r_cnt     <= LP_HOLD_LAST;
                                r_state   <= S_HOLD;
`ifdef ALU_SEL_RR_EN
                                r_rr      <= w_next_idx + 2'd1;
`endif
                            end else begin
                                r_done <= 1'b1;
                            end
                        end
                    end
                    S_HOLD: begin
                        if (r_cnt != '0) begin
                            r_cnt <= r_cnt - LP_ONE;
                        end else if (w_rem != 4'd0) begin
                            // Next op loads on the same edge so enable stays high with no gap.
                            r_pending <= w_src;
                            r_idx     <= w_next_idx;
                            r_cnt     <= LP_HOLD_LAST;
`ifdef ALU_SEL_RR_EN
                            r_rr      <= w_next_idx + 2'd1;
`endif
                        end else begin
                            r_pending <= 4'd0;
                            r_en      <= 1'b0;
                            r_busy    <= 1'b0;
                            r_done    <= 1'b1;
                            r_state   <= S_IDLE;
                        end
                    end
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_alu_sel_sequencer.sv
// Bench for alu_sel_sequencer: three instances (HOLD_CYCLES 1/2/3) against a schedule-based model.
module tb_alu_sel_sequencer;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic [3:0] req = 4'd0;
    logic       req_valid = 1'b0;
    logic       flush = 1'b0;
    logic [2:0] s0, s1, en, bsy, dn, rdy;

    alu_sel_sequencer #(.HOLD_CYCLES(1), .HOLD_W(4)) u_h1 (
        .clk(clk), .rst_n(rst_n), .req(req), .req_valid(req_valid), .req_ready(rdy[0]),
        .flush(flush), .sel_s0(s0[0]), .sel_s1(s1[0]), .sel_enable(en[0]), .busy(bsy[0]),
        .batch_done(dn[0]));
    alu_sel_sequencer #(.HOLD_CYCLES(2), .HOLD_W(4)) u_h2 (
        .clk(clk), .rst_n(rst_n), .req(req), .req_valid(req_valid), .req_ready(rdy[1]),
        .flush(flush), .sel_s0(s0[1]), .sel_s1(s1[1]), .sel_enable(en[1]), .busy(bsy[1]),
        .batch_done(dn[1]));
    alu_sel_sequencer #(.HOLD_CYCLES(3), .HOLD_W(4)) u_h3 (
        .clk(clk), .rst_n(rst_n), .req(req), .req_valid(req_valid), .req_ready(rdy[2]),
        .flush(flush), .sel_s0(s0[2]), .sel_s1(s1[2]), .sel_enable(en[2]), .busy(bsy[2]),
        .batch_done(dn[2]));

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    localparam int HS [3] = '{1, 2, 3};

    // Model: each accepted batch becomes a per-cycle list of op indices (bit 2 marks an op's first cycle).
    int sched [3][64];
    int mlen  [3];
    int mpos  [3];
    int msel  [3];
    int mdone [3];
    int mrr   [3];

    task automatic chk(input string nm, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    initial begin
        for (int h = 0; h < 3; h++) begin
            mlen[h] = 0; mpos[h] = 0; msel[h] = 0; mdone[h] = 0; mrr[h] = 0;
        end
        forever begin
            @(posedge clk or negedge rst_n);
            for (int h = 0; h < 3; h++) begin
                if (!rst_n) begin
                    mlen[h] = 0; mpos[h] = 0; msel[h] = 0; mdone[h] = 0; mrr[h] = 0;
                end else begin
                    int d, n, b;
                    d = 0;
                    if (flush) begin
                        mlen[h] = 0; mpos[h] = 0;
                    end else if (mpos[h] < mlen[h]) begin
                        mpos[h]++;
                        if (mpos[h] == mlen[h]) begin
                            d = 1; mlen[h] = 0; mpos[h] = 0;
                        end
                    end else if (req_valid) begin
                        if (req == 4'd0) begin
                            d = 1;
                        end else begin
                            n = 0;
                            for (int k = 0; k < 4; k++) begin
                                b = (mrr[h] + k) % 4;
                                if (req[b]) begin
                                    for (int c = 0; c < HS[h]; c++) begin
                                        sched[h][n] = b + ((c == 0) ? 4 : 0);
                                        n++;
                                    end
                                end
                            end
                            mlen[h] = n; mpos[h] = 0;
                        end
                    end
                    mdone[h] = d;
                    if (mpos[h] < mlen[h]) begin
                        msel[h] = sched[h][mpos[h]] % 4;
`ifdef ALU_SEL_RR_EN
                        if (sched[h][mpos[h]] >= 4) mrr[h] = (msel[h] + 1) % 4;
`endif
                    end
                end
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            for (int h = 0; h < 3; h++) begin
                int mb;
                mb = (mpos[h] < mlen[h]) ? 1 : 0;
                chk($sformatf("sel_enable_h%0d", HS[h]), en[h], mb);
                chk($sformatf("busy_h%0d", HS[h]), bsy[h], mb);
                chk($sformatf("sel_h%0d", HS[h]), {s1[h], s0[h]}, msel[h]);
                chk($sformatf("batch_done_h%0d", HS[h]), dn[h], mdone[h]);
                chk($sformatf("req_ready_h%0d", HS[h]), rdy[h], (mb == 0 && !flush) ? 1 : 0);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic go(input logic [3:0] r);
        req = r;
        req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
    endtask

    task automatic waitidle();
        for (int i = 0; i < 200 && bsy != 3'b000; i++) tick();
        chk("idle_timeout", bsy, 0);
    endtask

    logic [17:0] seqv;
    int ncyc, ndone;

    initial begin
        #1 rst_n = 1'b0;
        req_valid = 1'b1;
        req = 4'hF;
        repeat (3) begin
            tick();
            chk("rst_enable", en, 0);
            chk("rst_busy", bsy, 0);
            chk("rst_done", dn, 0);
            chk("rst_sel", {s1, s0}, 0);
        end
        req_valid = 1'b0;
        rst_n = 1'b1;
        tick();
        chk("post_rst_ready", rdy, 7);
        chk("post_rst_busy", bsy, 0);

        // Multi-op, HOLD_CYCLES=3 instance, with a request while busy that must be ignored.
        go(4'b1011);
        seqv = '0; ncyc = 0; ndone = 0;
        for (int i = 0; i < 12; i++) begin
            if (i == 1) begin req = 4'hF; req_valid = 1'b1; end
            if (i == 2) req_valid = 1'b0;
            @(negedge clk);
            if (en[2]) begin seqv = {seqv[15:0], s1[2], s0[2]}; ncyc++; end
            if (dn[2]) ndone++;
            @(posedge clk);
            #2;
        end
        chk("multi_seq", seqv, 18'b00_00_00_01_01_01_11_11_11);
        chk("multi_en_cycles", ncyc, 9);
        chk("multi_done_count", ndone, 1);
        waitidle();

        // Single op, HOLD_CYCLES=1 instance.
        go(4'b0100);
        chk("single_s1", s1[0], 1);
        chk("single_s0", s0[0], 0);
        chk("single_en", en[0], 1);
        tick();
        chk("single_en_off", en[0], 0);
        chk("single_done", dn[0], 1);
        chk("single_ready", rdy[0], 1);
        waitidle();

        // Empty request.
        go(4'b0000);
        chk("empty_en", en, 0);
        chk("empty_done", dn, 7);
        tick();
        chk("empty_done_off", dn, 0);

        // Flush in IDLE blocks acceptance.
        flush = 1'b1; req = 4'b0011; req_valid = 1'b1;
        #1 chk("flush_idle_ready", rdy, 0);
        tick();
        chk("flush_idle_en", en, 0);
        flush = 1'b0; req_valid = 1'b0;
        tick();

        // Flush during the 3rd active cycle.
        go(4'hF);
        tick();
        tick();
        flush = 1'b1;
        tick();
        chk("flush_en", en, 0);
        chk("flush_busy", bsy, 0);
        chk("flush_done", dn, 0);
        flush = 1'b0;
        tick();
        chk("flush_done_after", dn, 0);

        // Asynchronous reset mid-hold.
        go(4'hF);
        tick();
        rst_n = 1'b0;
        #1;
        chk("arst_en", en, 0);
        chk("arst_busy", bsy, 0);
        chk("arst_sel", {s1, s0}, 0);
        chk("arst_done", dn, 0);
        tick();
        rst_n = 1'b1;
        tick();
        chk("arst_ready", rdy, 7);

`ifdef ALU_SEL_RR_EN
        go(4'b0011); chk("rr_b1_op0", {s1[0], s0[0]}, 0);
        tick();      chk("rr_b1_op1", {s1[0], s0[0]}, 1);
        tick();
        go(4'b0011); chk("rr_b2_op0", {s1[0], s0[0]}, 0);
        tick();      chk("rr_b2_op1", {s1[0], s0[0]}, 1);
        tick();
        waitidle();
        go(4'b1001); chk("rr_b3_op0", {s1[0], s0[0]}, 3);
        tick();      chk("rr_b3_op1", {s1[0], s0[0]}, 0);
        waitidle();
`endif

        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            req = 4'($urandom);
            req_valid = 1'($urandom % 2);
            flush = ($urandom % 16) == 0;
            tick();
        end
        req_valid = 1'b0;
        flush = 1'b0;
        waitidle();
        tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
